// File: rtl/mmio_bus_initiator_if.sv
// Command, response and native memory bus signals of the MMIO bus initiator.
// master = initiator side, slave = command source / bus responder side.
interface mmio_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_wstrb,
    input  rsp_ready, mem_rdata, mem_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_wstrb,
    output rsp_ready, mem_rdata, mem_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, busy
  );
endinterface

// File: rtl/mmio_bus_initiator.sv
// Command-driven read / write / masked RMW initiator for the native memory bus.
// Optional MMIO_ALIGN_CHECK_EN: reject non word-aligned command addresses with an error.
module mmio_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  reset,
  mmio_bus_initiator_if.master bus
);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_RMW    = 2'b10;
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] wdata_q;
  logic [31:0] mask_q;
  logic [31:0] pre_q;
  logic [7:0]  tmo_cnt;
  logic        align_fault;
  logic        bad_cmd;
  logic        tmo_hit;
  logic [31:0] word_addr;

`ifdef MMIO_ALIGN_CHECK_EN
  assign align_fault = (bus.cmd_addr[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  assign word_addr = {bus.cmd_addr[31:2], 2'b00};
  assign bad_cmd   = align_fault || (bus.cmd_op == 2'b11);
  // A ready on the same edge the counter reaches the limit still wins.
  assign tmo_hit   = ((tmo_cnt + 8'd1) == TMO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= OP_READ;
      wdata_q       <= '0;
      mask_q        <= '0;
      pre_q         <= '0;
      tmo_cnt       <= '0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q          <= bus.cmd_op;
            wdata_q       <= bus.cmd_wdata;
            mask_q        <= bus.cmd_mask;
            tmo_cnt       <= '0;
            bus.mem_addr  <= word_addr;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (bad_cmd) begin
              state         <= RSP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else if (bus.cmd_op == OP_WRITE) begin
              if (bus.cmd_wstrb != 4'h0) begin
                state         <= WR;
                bus.mem_valid <= 1'b1;
                bus.mem_wstrb <= bus.cmd_wstrb;
                bus.mem_wdata <= bus.cmd_wdata;
              end else begin
                // All strobes off: nothing to put on the bus, acknowledge at once.
                state         <= RSP;
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b0;
                bus.rsp_rdata <= '0;
              end
            end else begin
              state         <= RD;
              bus.mem_valid <= 1'b1;
              bus.mem_wstrb <= 4'h0;
            end
          end
        end

        RD: begin
          if (bus.mem_ready) begin
            pre_q <= bus.mem_rdata;
            if (op_q == OP_RMW) begin
              state         <= WR;
              tmo_cnt       <= '0;
              bus.mem_wdata <= (bus.mem_rdata & ~mask_q) | (wdata_q & mask_q);
              bus.mem_wstrb <= 4'hF;
            end else begin
              state         <= RSP;
              bus.mem_valid <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              bus.rsp_rdata <= bus.mem_rdata;
            end
          end else if (tmo_hit) begin
            state         <= RSP;
            bus.mem_valid <= 1'b0;
            bus.mem_wstrb <= 4'h0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        WR: begin
          if (bus.mem_ready) begin
            state         <= RSP;
            bus.mem_valid <= 1'b0;
            bus.mem_wstrb <= 4'h0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= (op_q == OP_RMW) ? pre_q : 32'h0;
          end else if (tmo_hit) begin
            state         <= RSP;
            bus.mem_valid <= 1'b0;
            bus.mem_wstrb <= 4'h0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RSP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          bus.mem_valid <= 1'b0;
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Randomized self-checking bench for mmio_bus_initiator: a memory responder with
// configurable wait states plus a transaction-level model of expected responses and bus phases.
`timescale 1ns/1ps
module tb_mmio_bus_initiator;

  localparam int TMO  = 16;
  localparam int HANG = 255;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cycles;
    bit          ok;
  } phase_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mmio_bus_initiator_if bus_if ();

  mmio_bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  phase_t      obs_q[$];
  phase_t      exp_q[$];
  logic [31:0] bus_mem   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  int          wait_cfg = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;

  int          cur_cnt = 0;
  bit          ready_given = 0;
  phase_t      last_ph;
  phase_t      done_ph;
  logic [31:0] resp_rd;
  logic [31:0] resp_nw;

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] strobe_merge(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic phase_t make_phase(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s, input int c, input bit ok);
    phase_t p;
    p.addr = a; p.wdata = d; p.wstrb = s; p.cycles = c; p.ok = ok;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    bus_mem[a]   = v;
    model_mem[a] = v;
  endtask

  // Responder: completes each phase after wait_cfg wait states (never for HANG) and
  // records every phase it saw, including ones abandoned by the initiator.
  always @(negedge clk) begin
    if (bus_if.mem_valid) begin
      if (ready_given) cur_cnt = 0;
      ready_given = 0;
      cur_cnt++;
      last_ph = make_phase(bus_if.mem_addr, bus_if.mem_wdata, bus_if.mem_wstrb, cur_cnt, 1'b0);
      if (wait_cfg != HANG && cur_cnt == wait_cfg + 1) begin
        resp_rd = bus_mem.exists(bus_if.mem_addr) ? bus_mem[bus_if.mem_addr] : default_word(bus_if.mem_addr);
        if (bus_if.mem_wstrb != 4'h0) begin
          resp_nw = strobe_merge(resp_rd, bus_if.mem_wdata, bus_if.mem_wstrb);
          bus_mem[bus_if.mem_addr] = resp_nw;
        end
        done_ph    = last_ph;
        done_ph.ok = 1'b1;
        obs_q.push_back(done_ph);
        ready_given      = 1;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = resp_rd;
      end else begin
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = $urandom;
      end
    end else begin
      if (cur_cnt > 0 && !ready_given) obs_q.push_back(last_ph);
      cur_cnt          = 0;
      ready_given      = 0;
      bus_if.mem_ready = 1'($urandom_range(0, 1));
      bus_if.mem_rdata = $urandom;
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] mask, input logic [3:0] wstrb, input int wt, input int hold);
    logic [31:0] waddr, old, merged, exp_rdata;
    logic        exp_err;
    bit          bad_align, ph_ok;
    int          ph_cycles, exp_lat, lat;

    waddr     = {addr[31:2], 2'b00};
    bad_align = 0;
`ifdef MMIO_ALIGN_CHECK_EN
    bad_align = (addr[1:0] != 2'b00);
`endif
    ph_ok     = (wt != HANG);
    ph_cycles = ph_ok ? wt + 1 : TMO;
    old       = model_mem.exists(waddr) ? model_mem[waddr] : default_word(waddr);
    exp_rdata = '0;
    exp_err   = 1'b0;
    exp_lat   = 1;
    exp_q.delete();
    obs_q.delete();

    if (bad_align || op == 2'b11) begin
      exp_err = 1'b1;
    end else if (op == 2'b01) begin
      if (wstrb != 4'h0) begin
        exp_q.push_back(make_phase(waddr, wdata, wstrb, ph_cycles, ph_ok));
        exp_lat += ph_cycles;
        if (ph_ok) model_mem[waddr] = strobe_merge(old, wdata, wstrb);
        else exp_err = 1'b1;
      end
    end else begin
      exp_q.push_back(make_phase(waddr, 32'h0, 4'h0, ph_cycles, ph_ok));
      exp_lat += ph_cycles;
      if (!ph_ok) begin
        exp_err = 1'b1;
      end else if (op == 2'b00) begin
        exp_rdata = old;
      end else begin
        merged = (old & ~mask) | (wdata & mask);
        exp_q.push_back(make_phase(waddr, merged, 4'hF, ph_cycles, 1'b1));
        exp_lat += ph_cycles;
        model_mem[waddr] = merged;
        exp_rdata = old;
      end
    end

    wait_cfg = wt;
    @(negedge clk);
    checkOutput("cmd_ready_idle", bus_if.cmd_ready, 1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wdata;
    bus_if.cmd_mask  = mask;
    bus_if.cmd_wstrb = wstrb;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = $urandom;
    bus_if.cmd_wdata = $urandom;
    bus_if.cmd_mask  = $urandom;
    bus_if.cmd_wstrb = 4'($urandom);
    lat = 1;
    while (!bus_if.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("rsp_valid_seen", bus_if.rsp_valid, 1);
    checkOutput("rsp_latency", lat, exp_lat);
    checkOutput("rsp_rdata", bus_if.rsp_rdata, exp_rdata);
    checkOutput("rsp_err", bus_if.rsp_err, exp_err);

    for (int i = 0; i < hold; i++) begin
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = 2'($urandom);
      @(negedge clk);
      checkOutput("hold_rsp_valid", bus_if.rsp_valid, 1);
      checkOutput("hold_rsp_rdata", bus_if.rsp_rdata, exp_rdata);
      checkOutput("hold_rsp_err", bus_if.rsp_err, exp_err);
      checkOutput("hold_cmd_ready", bus_if.cmd_ready, 0);
      checkOutput("hold_busy", bus_if.busy, 1);
    end

    bus_if.cmd_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    checkOutput("post_rsp_valid", bus_if.rsp_valid, 0);
    checkOutput("post_rsp_err", bus_if.rsp_err, 0);
    checkOutput("post_cmd_ready", bus_if.cmd_ready, 1);
    checkOutput("post_busy", bus_if.busy, 0);

    checkOutput("phase_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checkOutput("phase_addr", obs_q[i].addr, exp_q[i].addr);
      checkOutput("phase_wstrb", obs_q[i].wstrb, exp_q[i].wstrb);
      checkOutput("phase_cycles", obs_q[i].cycles, exp_q[i].cycles);
      checkOutput("phase_ok", obs_q[i].ok, exp_q[i].ok);
      if (exp_q[i].wstrb != 4'h0) checkOutput("phase_wdata", obs_q[i].wdata, exp_q[i].wdata);
    end
  endtask

  task automatic resetDuringRmw();
    logic [31:0] waddr, old, merged;
    int          guard;
    waddr  = 32'h2000_0010;
    old    = model_mem.exists(waddr) ? model_mem[waddr] : default_word(waddr);
    merged = (old & ~32'h00FF_0000) | (32'h1234_5678 & 32'h00FF_0000);
    wait_cfg = 3;
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 2'b10;
    bus_if.cmd_addr  = waddr;
    bus_if.cmd_wdata = 32'h1234_5678;
    bus_if.cmd_mask  = 32'h00FF_0000;
    bus_if.cmd_wstrb = 4'h0;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    guard = 0;
    while (!(bus_if.mem_valid && bus_if.mem_wstrb == 4'hF) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rst_wr_phase_seen", (bus_if.mem_valid && bus_if.mem_wstrb == 4'hF), 1);
    checkOutput("rst_wr_merged", bus_if.mem_wdata, merged);
    reset = 1'b1;
    #1;
    checkOutput("rst_mem_valid", bus_if.mem_valid, 0);
    checkOutput("rst_rsp_valid", bus_if.rsp_valid, 0);
    checkOutput("rst_busy", bus_if.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", bus_if.cmd_ready, 1);
    checkOutput("rst_no_rsp", bus_if.rsp_valid, 0);
    obs_q.delete();
  endtask

  initial begin
    int          r, wt;
    logic [1:0]  op;
    logic [31:0] addr;

    reset            = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 2'b00;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;
    bus_if.cmd_mask  = '0;
    bus_if.cmd_wstrb = '0;
    bus_if.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_cmd_ready", bus_if.cmd_ready, 1);
    checkOutput("reset_rsp_valid", bus_if.rsp_valid, 0);
    checkOutput("reset_rsp_rdata", bus_if.rsp_rdata, 0);
    checkOutput("reset_rsp_err", bus_if.rsp_err, 0);
    checkOutput("reset_mem_valid", bus_if.mem_valid, 0);
    checkOutput("reset_mem_addr", bus_if.mem_addr, 0);
    checkOutput("reset_mem_wdata", bus_if.mem_wdata, 0);
    checkOutput("reset_mem_wstrb", bus_if.mem_wstrb, 0);
    checkOutput("reset_busy", bus_if.busy, 0);
    reset = 1'b0;

    applyStimulus(2'b01, 32'h2000_0004, 32'hFFFF_FFFF, 32'h0, 4'hF, 0, 0);
    preload(32'h2000_0000, 32'h0000_00A5);
    applyStimulus(2'b00, 32'h2000_0000, 32'h0, 32'h0, 4'h0, 3, 0);
    preload(32'h2000_0000, 32'hFFFF_00F0);
    applyStimulus(2'b10, 32'h2000_0000, 32'h0000_0003, 32'h0000_000F, 4'h0, 0, 0);
    applyStimulus(2'b00, 32'h2000_0008, 32'h0, 32'h0, 4'h0, HANG, 0);
    applyStimulus(2'b11, 32'h2000_0000, 32'h0, 32'h0, 4'h0, 0, 5);
    applyStimulus(2'b01, 32'h2000_000C, 32'hDEAD_BEEF, 32'h0, 4'h0, 0, 5);
    applyStimulus(2'b00, 32'h2000_0004, 32'h0, 32'h0, 4'h0, TMO - 1, 0);
    applyStimulus(2'b10, 32'h2000_0014, 32'hAAAA_5555, 32'hF0F0_F0F0, 4'h0, HANG, 1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      addr = 32'h2000_0000 + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      wt = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 3) : (r == 8) ? TMO - 1 : HANG;
      applyStimulus(op, addr, $urandom, $urandom, 4'($urandom), wt, $urandom_range(0, 3));
    end

    resetDuringRmw();
    applyStimulus(2'b01, 32'h2000_0010, 32'hCAFE_F00D, 32'h0, 4'h3, 1, 0);
    applyStimulus(2'b00, 32'h2000_0010, 32'h0, 32'h0, 4'h0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mmio_bus_initiator.md
Name: mmio_bus_initiator

Overview:
- Command-driven initiator for the native memory bus (mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_rdata/mem_ready).
- Lets a non-CPU agent (test sequencer, boot loader, UART debug bridge) program MMIO responders such as the GPIO block at 0x2000_0000.
- Supports read, write and masked read-modify-write (RMW); one command in flight; per-phase timeout.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles mem_valid stays high waiting for mem_ready before abort; legal range 1..255.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_op  input  2  00 read, 01 write, 10 RMW, 11 reserved
- cmd_addr  input  32  target byte address
- cmd_wdata  input  32  write data (RMW: new bit values)
- cmd_mask  input  32  RMW bit mask, 1 = replace bit
- cmd_wstrb  input  4  byte strobes for write op (ignored for read/RMW)
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  output  32  read data (RMW: pre-modify value); 0 on write or error
- rsp_err  output  1  1 = timeout / reserved op / alignment fault
- mem_valid  output  1  bus request
- mem_addr  output  32  bus address
- mem_wdata  output  32  bus write data
- mem_wstrb  output  4  bus strobes, 0 = read
- mem_rdata  input  32  responder read data, valid when mem_ready
- mem_ready  input  1  responder completion; tie 1 for zero-wait responders
- busy  output  1  state != IDLE

Behaviour:
- Reset, asynchronous: state IDLE; cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_valid=0; mem_addr=0; mem_wdata=0; mem_wstrb=0; busy=0; timeout counter=0.
- All outputs are registered. cmd_ready = (state==IDLE).
- On accept, latch op/addr/wdata/mask/wstrb.
- States:
  - IDLE
  - RD: mem_valid=1, mem_wstrb=0.
  - WR: mem_valid=1, strobes per op.
  - RSP: rsp_valid=1, held until rsp_ready.
- Accept-cycle transitions:
  - read -> RD.
  - write with cmd_wstrb != 0 -> WR with mem_wstrb=cmd_wstrb, mem_wdata=cmd_wdata.
  - write with cmd_wstrb == 0 -> RSP directly: no bus cycle, err=0, rdata=0.
  - RMW -> RD.
  - op 11 -> RSP with err=1, no bus cycle.
- Bus phase completes on the rising edge where mem_valid && mem_ready. mem_valid drops the following cycle. mem_addr/mem_wdata/mem_wstrb stay stable for the whole phase.
- RD completion:
  - Capture mem_rdata.
  - Read op -> RSP.
  - RMW -> WR the next cycle with mem_wdata = (rdata & ~mask) | (wdata & mask), mem_wstrb=4'hF, same address.
- WR completion -> RSP. rsp_rdata = 0 for write, captured pre-modify value for RMW.
- Latency with mem_ready tied 1:
  - Accept at edge 0, mem_valid high in cycle 1, rsp_valid high in cycle 2.
  - RMW: rsp_valid high in cycle 3.
- Back-to-back commands: earliest next accept is the cycle after rsp handshake.
- Timeout:
  - Counter clears on phase entry and increments each cycle mem_valid && !mem_ready.
  - Reaching TIMEOUT_CYCLES: drop mem_valid, go RSP with err=1, rdata=0.
  - RMW timeout in RD aborts without issuing WR.
- mem_ready while mem_valid=0 is ignored.
- mem_ready on the same edge the count hits the limit counts as success.
- RSP: rsp_valid and rsp_* stable until rsp_ready. On handshake, return to IDLE and clear rsp_err.
- Reset mid-phase: mem_valid drops asynchronously and the command is lost, no response.

Optional Feature:
- Macro MMIO_ALIGN_CHECK_EN.
- Defined: any command with cmd_addr[1:0] != 0 goes straight to RSP with err=1, no bus cycle.
- Undefined: no check; mem_addr is driven with bits [1:0] forced to 0.

Test Plan:
- Write 0x2000_0004 data 0xFFFF_FFFF wstrb F, mem_ready=1 -> one cycle with mem_valid=1/addr 0x2000_0004/wstrb F; rsp_valid two cycles after accept, err=0, rdata=0.
- Read 0x2000_0000, responder returns 0x0000_00A5 after 3 wait cycles -> mem_valid high 4 cycles, wstrb 0; rsp_rdata=0x0000_00A5, err=0.
- RMW 0x2000_0000, mask 0x0000_000F, wdata 0x0000_0003, read returns 0xFFFF_00F0 -> read phase, then write phase wdata 0xFFFF_00F3 wstrb F; rsp_rdata=0xFFFF_00F0.
- Read with mem_ready held 0, TIMEOUT_CYCLES=16 -> mem_valid high exactly 16 cycles; rsp_err=1, rsp_rdata=0; the next command is accepted afterwards.
- Op 11, then a write with wstrb 0 -> both give a response with no mem_valid pulse; errors 1 and 0 respectively. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_* stable, cmd_ready=0.
- Assert reset during an RMW write phase -> mem_valid, rsp_valid, busy go 0 immediately; cmd_ready=1 after release.
